// File: rtl/fir_tap_loader.sv
// fir_tap_loader
// ---------------------------------------------------------------------------
// Loads a new bank of FIR coefficients one word at a time into a shadow
// buffer and then publishes the whole bank to the filter in a single cycle.
// The filter therefore never sees a half-loaded bank.
//
// Configuration macro:
//   TAP_LOADER_SYMMETRIC_EN  when defined, only ceil(NUMBER_OF_TAPS/2) words
//                            are loaded. Each word is written to both h[i]
//                            and h[NUMBER_OF_TAPS-1-i], which suits a
//                            linear-phase (symmetric) filter.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset
//   load_start  one-cycle request to begin (or restart) a coefficient load
//   tap_valid   tap_data carries a coefficient
//   tap_data    signed coefficient word; the first accepted word is h[0]
//   tap_ready   high while a load is accepting words
//   h           active coefficient bank, driven to the FIR filter
//   busy        high while a load or commit is in progress
//   done        one-cycle pulse when a new bank becomes active
//   abort       one-cycle pulse when an in-progress load is restarted
// ---------------------------------------------------------------------------
module fir_tap_loader #(
  parameter int NUMBER_OF_TAPS = 63,
  parameter int DATA_WIDTH     = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load_start,
  input  logic                         tap_valid,
  input  logic signed [DATA_WIDTH-1:0] tap_data,
  output logic                         tap_ready,
  output logic signed [DATA_WIDTH-1:0] h [0:NUMBER_OF_TAPS-1],
  output logic                         busy,
  output logic                         done,
  output logic                         abort
);

`ifdef TAP_LOADER_SYMMETRIC_EN
  localparam int LOAD_COUNT = (NUMBER_OF_TAPS + 1) / 2;
`else
  localparam int LOAD_COUNT = NUMBER_OF_TAPS;
`endif

  localparam int CNT_W = (LOAD_COUNT > 1) ? $clog2(LOAD_COUNT) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LOAD_COUNT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t                         state_q, state_d;
  logic [CNT_W-1:0]               count_q, count_d;
  logic signed [DATA_WIDTH-1:0]   shadow_q [0:LOAD_COUNT-1];
  logic signed [DATA_WIDTH-1:0]   shadow_d [0:LOAD_COUNT-1];
  logic signed [DATA_WIDTH-1:0]   h_q      [0:NUMBER_OF_TAPS-1];
  logic signed [DATA_WIDTH-1:0]   h_d      [0:NUMBER_OF_TAPS-1];
  logic signed [DATA_WIDTH-1:0]   commit_bank [0:NUMBER_OF_TAPS-1];
  logic                           done_q, done_d;
  logic                           abort_q, abort_d;

  // Static shadow-to-bank routing. In the plain build this is the identity.
  // In the symmetric build the upper half of the bank mirrors the lower half.
  for (genvar gi = 0; gi < NUMBER_OF_TAPS; gi++) begin : g_map
    localparam int SRC = (gi < LOAD_COUNT) ? gi : (NUMBER_OF_TAPS - 1 - gi);
    assign commit_bank[gi] = shadow_q[SRC];
  end

  // Next-state / datapath
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    shadow_d = shadow_q;
    h_d      = h_q;
    done_d   = 1'b0;
    abort_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (load_start) begin
          state_d = S_LOAD;
          count_d = '0;
        end
      end
      S_LOAD: begin
        // A restart has priority over a word presented in the same cycle.
        // That word is dropped so the new load begins cleanly at h[0].
        if (load_start) begin
          count_d = '0;
          abort_d = 1'b1;
        end else if (tap_valid) begin
          shadow_d[count_q] = tap_data;
          if (count_q == LAST_IDX) begin
            count_d = '0;
            state_d = S_COMMIT;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
      end
      S_COMMIT: begin
        // load_start is deliberately ignored here; the commit always completes.
        h_d     = commit_bank;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and bank registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      for (int i = 0; i < LOAD_COUNT; i++) begin
        shadow_q[i] <= '0;
      end
      for (int i = 0; i < NUMBER_OF_TAPS; i++) begin
        h_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      done_q   <= done_d;
      abort_q  <= abort_d;
      shadow_q <= shadow_d;
      h_q      <= h_d;
    end
  end

  assign tap_ready = (state_q == S_LOAD);
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign abort     = abort_q;
  assign h         = h_q;

endmodule

// File: tb/tb_fir_tap_loader.sv
// tb_fir_tap_loader
// Randomised and directed bench for fir_tap_loader. The reference model
// tracks a load as a queue of accepted words and publishes the whole queue
// into an expected bank one cycle after the final word is accepted.
`timescale 1ns/1ps
module tb_fir_tap_loader;
  localparam int N = 63;
  localparam int W = 10;
`ifdef TAP_LOADER_SYMMETRIC_EN
  localparam int LC  = (N + 1) / 2;
  localparam bit SYM = 1'b1;
`else
  localparam int LC  = N;
  localparam bit SYM = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst;
  logic                load_start;
  logic                tap_valid;
  logic signed [W-1:0] tap_data;
  logic                tap_ready;
  logic signed [W-1:0] h [0:N-1];
  logic                busy;
  logic                done;
  logic                abort;

  fir_tap_loader #(.NUMBER_OF_TAPS(N), .DATA_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .tap_valid(tap_valid),
    .tap_data(tap_data), .tap_ready(tap_ready), .h(h), .busy(busy),
    .done(done), .abort(abort)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit                  m_loading;
  bit                  m_commit;
  logic signed [W-1:0] m_q [$];
  logic signed [W-1:0] exp_h [0:N-1];
  bit                  exp_done;
  bit                  exp_abort;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_loading = 1'b0;
      m_commit  = 1'b0;
      m_q.delete();
      exp_done  = 1'b0;
      exp_abort = 1'b0;
      for (int i = 0; i < N; i++) exp_h[i] = '0;
    end else begin
      exp_done  = 1'b0;
      exp_abort = 1'b0;
      if (m_commit) begin
        for (int i = 0; i < LC; i++) begin
          exp_h[i] = m_q[i];
          if (SYM) exp_h[N-1-i] = m_q[i];
        end
        m_q.delete();
        m_commit = 1'b0;
        exp_done = 1'b1;
      end else if (m_loading) begin
        if (load_start) begin
          m_q.delete();
          exp_abort = 1'b1;
        end else if (tap_valid) begin
          m_q.push_back(tap_data);
          if (m_q.size() == LC) begin
            m_loading = 1'b0;
            m_commit  = 1'b1;
          end
        end
      end else if (load_start) begin
        m_loading = 1'b1;
        m_q.delete();
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  int done_cnt, abort_cnt, busy_cnt;

  always @(negedge clk) begin
    int bad;
    check("tap_ready", int'(tap_ready), int'(m_loading));
    check("busy", int'(busy), int'(m_loading || m_commit));
    check("done", int'(done), int'(exp_done));
    check("abort", int'(abort), int'(exp_abort));
    bad = -1;
    for (int i = N - 1; i >= 0; i--) if (h[i] !== exp_h[i]) bad = i;
    n_checks++;
    if (bad >= 0) begin
      n_errors++;
      $display("FAIL bank h[%0d]: got %0d, expected %0d (t=%0t)", bad, h[bad], exp_h[bad], $time);
    end
    if (done)  done_cnt++;
    if (abort) abort_cnt++;
    if (busy)  busy_cnt++;
  end

  // ---------------- stimulus helpers ----------------
  logic signed [W-1:0] seq [0:N-1];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    done_cnt = 0; abort_cnt = 0; busy_cnt = 0;
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    tap_valid  = 1'b0;
    tick();
    load_start = 1'b0;
  endtask

  task automatic send_seq(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      tap_valid = 1'b1;
      tap_data  = seq[i];
      tick();
      if (gaps) begin
        tap_valid = 1'b0;
        tap_data  = W'($urandom);
        tick();
      end
    end
    tap_valid = 1'b0;
  endtask

  function automatic int bank_mism();
    int m;
    int s;
    m = 0;
    for (int i = 0; i < N; i++) begin
      s = (i < LC) ? i : (N - 1 - i);
      if (h[i] !== seq[s]) m++;
    end
    return m;
  endfunction

  function automatic int count_value(input int v);
    int c;
    c = 0;
    for (int i = 0; i < N; i++) if (int'(h[i]) == v) c++;
    return c;
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish, expected finish before 900000ns");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; load_start = 1'b0; tap_valid = 1'b0; tap_data = '0;
    clear_counts();
    repeat (3) tick();
    check("reset busy", int'(busy), 0);
    check("reset tap_ready", int'(tap_ready), 0);
    check("reset h zero entries", count_value(0), N);
    rst = 1'b0;
    tick();

    // tap_valid while idle must not start anything
    tap_valid = 1'b1; tap_data = 10'sd7;
    repeat (3) tick();
    tap_valid = 1'b0;
    check("idle valid busy", int'(busy), 0);

    // full load, values i+1
    for (int i = 0; i < N; i++) seq[i] = W'(i + 1);
    clear_counts();
    pulse_start();
    send_seq(LC, 1'b0);
    check("done before commit edge", int'(done), 0);
    tick();
    check("done one edge after last tap", int'(done), 1);
    check("full h[0]", int'(h[0]), 1);
    check("full h[last]", int'(h[N-1]), SYM ? 1 : 63);
    repeat (3) tick();
    check("full done pulses", done_cnt, 1);
    check("full busy cycles", busy_cnt, LC + 1);

    // backpressure: valid toggles 1,0,1,0
    for (int i = 0; i < N; i++) seq[i] = W'($urandom);
    clear_counts();
    pulse_start();
    send_seq(LC, 1'b1);
    repeat (3) tick();
    check("backpressure bank mismatches", bank_mism(), 0);
    check("backpressure busy cycles", busy_cnt, 2 * LC);
    check("backpressure done pulses", done_cnt, 1);

    // abort: 20 words of 3FF, restart with a colliding word, then all 001
    for (int i = 0; i < N; i++) seq[i] = 10'sh3FF;
    clear_counts();
    pulse_start();
    send_seq(20, 1'b0);
    load_start = 1'b1; tap_valid = 1'b1; tap_data = 10'sh3FF;
    tick();
    load_start = 1'b0; tap_valid = 1'b0;
    for (int i = 0; i < N; i++) seq[i] = 10'sd1;
    send_seq(LC, 1'b0);
    // load_start during the commit cycle is ignored
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    repeat (3) tick();
    check("abort pulses", abort_cnt, 1);
    check("abort done pulses", done_cnt, 1);
    check("abort all ones", count_value(1), N);
    check("abort no 3FF", count_value(-1), 0);
    check("commit-start busy", int'(busy), 0);

    // reset in the middle of a load that follows a bank of 005
    for (int i = 0; i < N; i++) seq[i] = 10'sd5;
    pulse_start();
    send_seq(LC, 1'b0);
    repeat (2) tick();
    check("bank of 5", count_value(5), N);
    pulse_start();
    send_seq(30, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("midload reset h zero", count_value(0), N);
    check("midload reset busy", int'(busy), 0);
    check("midload reset ready", int'(tap_ready), 0);
    check("midload reset done", int'(done), 0);
    check("midload reset abort", int'(abort), 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < N; i++) seq[i] = W'($urandom);
    clear_counts();
    pulse_start();
    send_seq(LC, 1'b0);
    repeat (3) tick();
    check("post-reset bank mismatches", bank_mism(), 0);
    check("post-reset done pulses", done_cnt, 1);

`ifdef TAP_LOADER_SYMMETRIC_EN
    for (int i = 0; i < N; i++) seq[i] = W'(i);
    clear_counts();
    pulse_start();
    send_seq(LC, 1'b0);
    repeat (3) tick();
    check("sym h[0]", int'(h[0]), 0);
    check("sym h[62]", int'(h[62]), 0);
    check("sym h[10]", int'(h[10]), 10);
    check("sym h[52]", int'(h[52]), 10);
    check("sym h[31]", int'(h[31]), 31);
    check("sym done pulses", done_cnt, 1);
`endif

    // randomised traffic, checked every cycle by the model
    for (int c = 0; c < 4000; c++) begin
      load_start = ($urandom_range(0, 60) == 0);
      tap_valid  = ($urandom_range(0, 2) != 0);
      tap_data   = W'($urandom);
      tick();
    end
    load_start = 1'b0;
    tap_valid  = 1'b0;
    repeat (5) tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
